gp_pixel_writer: RTL and testbench

- Sits directly downstream of the MEM stage. Captures the pixel bytes produced by GP (OpCode 10) instructions and buffers them in a small FIFO.
- Drains the FIFO into the output frame memory through a ready/valid write port, generating sequential addresses.
- Signals frame completion after FRAME_PIXELS writes and back-pressures the pipeline when the FIFO is full.

---
 rtl/gp_pixel_writer.sv | 163 ++++++++++++++++
 tb/tb_gp_pixel_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_pixel_writer.sv
// gp_pixel_writer
// Captures pixel bytes from GP instructions leaving the MEM stage, buffers
// them in a small FIFO and drains them into the frame memory at sequential
// addresses. Signals frame completion, back-pressures MEM while the FIFO is
// full, and flags pixels that arrive after the frame has no room left.
module gp_pixel_writer #(
  parameter int FRAME_PIXELS = 153600,
  parameter int ADDR_W       = 18,
  parameter int DEPTH        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        op_code,
  input  logic [31:0]       alu_result,
  input  logic              frame_start,
  output logic              stall,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] pix_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [4:0] OP_GP = 5'd10;

  // Occupancy and frame bookkeeping are compared in one extra bit so the
  // sum of written and buffered pixels can reach FRAME_PIXELS without wrap.
  localparam logic [ADDR_W:0]   FRAME_CNT = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             gp;
  logic             active;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ADDR_W:0]  pending;
  logic             room;
  logic             push;
  logic             pop;
  logic             drop_ovf;
  logic             last_pop;

  // Decode this cycle's pixel request, FIFO status and write handshake.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gp         = 1'b0;
    active     = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;
    pending    = '0;
    room       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    drop_ovf   = 1'b0;
    last_pop   = 1'b0;

    gp         = (op_code == OP_GP);
    active     = (state == ACTIVE);
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);

    // Pixels already written plus pixels waiting; the frame can take more
    // only while this stays below the frame size.
    pending    = {1'b0, pix_count} + (ADDR_W+1)'(count);
    room       = (pending < FRAME_CNT);

    // Fullness is judged before any pop this cycle, so a pixel presented
    // to a full FIFO is stalled even if a write drains an entry.
    push       = active && gp && room && !fifo_full && !frame_start;
    pop        = active && !fifo_empty && out_ready;
    last_pop   = pop && (pix_count == LAST_ADDR);

    // Pixels with nowhere to go: after the frame finished, or more than
    // the frame can still hold. These never stall MEM.
    drop_ovf   = gp && !frame_start &&
                 ((state == DONE) || (active && !room));
  end

  // Back-pressure and write-port view derived from registered state.
  always_comb begin
    stall    = 1'b0;
    out_we   = 1'b0;
    out_data = 8'h00;

    stall    = active && gp && room && fifo_full;
    out_we   = active && !fifo_empty;
    if (!fifo_empty) out_data = mem[rd_ptr];
  end

  assign out_addr = pix_count;

  // Pixel storage; written only on an accepted push.
  // NOTE: the array is deliberately left out of reset; the count register
  // marks which entries are valid, and out_data is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= alu_result[7:0];
  end

  // Frame FSM with FIFO pointers, pixel counter and status flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pix_count  <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (frame_start) begin
        // Start or restart a frame: discard anything buffered and any
        // progress or overflow from the previous one.
        state     <= ACTIVE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        pix_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);

        if (pop) begin
          rd_ptr    <= rd_ptr + PTR_W'(1);
          pix_count <= pix_count + ADDR_W'(1);
        end

        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase

        if (drop_ovf) overflow <= 1'b1;

        if (last_pop) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gp_pixel_writer.sv
// Directed bench for gp_pixel_writer. One instance uses the default frame
// size; a second uses an 8-pixel frame to reach completion and overflow.
module tb_gp_pixel_writer;

  localparam int AW = 18;

  logic          clk;
  logic          rst;

  logic [4:0]    op_code;
  logic [31:0]   alu_result;
  logic          frame_start;
  logic          out_ready;
  logic          stall;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic          frame_done;
  logic          overflow;
  logic [AW-1:0] pix_count;

  logic [4:0]    op_code8;
  logic [31:0]   alu_result8;
  logic          frame_start8;
  logic          out_ready8;
  logic          stall8;
  logic          out_we8;
  logic [AW-1:0] out_addr8;
  logic [7:0]    out_data8;
  logic          frame_done8;
  logic          overflow8;
  logic [AW-1:0] pix_count8;

  int total;
  int bad;

  gp_pixel_writer dut (
    .clk(clk), .rst(rst), .op_code(op_code), .alu_result(alu_result),
    .frame_start(frame_start), .stall(stall), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
    .frame_done(frame_done), .overflow(overflow), .pix_count(pix_count)
  );

  gp_pixel_writer #(.FRAME_PIXELS(8)) dut8 (
    .clk(clk), .rst(rst), .op_code(op_code8), .alu_result(alu_result8),
    .frame_start(frame_start8), .stall(stall8), .out_we(out_we8),
    .out_addr(out_addr8), .out_data(out_data8), .out_ready(out_ready8),
    .frame_done(frame_done8), .overflow(overflow8), .pix_count(pix_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logs, frame_done counters and stall tracking, sampled mid-cycle.
  logic [31:0] log_q[$];
  logic [31:0] log8_q[$];
  int cyc_n;
  int fd_cnt;
  int fd8_cnt;
  int fd8_cyc;
  int hs7_cyc;
  bit stall_seen;
  bit stall8_seen;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (rst) begin
      if (out_we && out_ready) log_q.push_back({6'b0, out_addr, out_data});
      if (out_we8 && out_ready8) begin
        log8_q.push_back({6'b0, out_addr8, out_data8});
        if (out_addr8 == 18'd7) hs7_cyc = cyc_n;
      end
      if (frame_done) fd_cnt++;
      if (frame_done8) begin
        fd8_cnt++;
        fd8_cyc = cyc_n;
      end
      if (stall) stall_seen = 1'b1;
      if (stall8) stall8_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    op_code    = 5'd10;
    alu_result = {24'h0, v};
    tick();
    op_code    = 5'd0;
  endtask

  task automatic push8(input logic [7:0] v);
    op_code8    = 5'd10;
    alu_result8 = {24'h0, v};
    tick();
    op_code8    = 5'd0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_fs8();
    frame_start8 = 1'b1;
    tick();
    frame_start8 = 1'b0;
  endtask

  function automatic logic [31:0] entry(input int addr, input int data);
    return {6'b0, addr[17:0], data[7:0]};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] log8_at(input int i);
    return (i < log8_q.size()) ? log8_q[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int cyc;
    bit s;

    total = 0; bad = 0; fd_cnt = 0; fd8_cnt = 0; fd8_cyc = -1; hs7_cyc = -2;
    rst = 1'b0;
    op_code = '0; alu_result = '0; frame_start = 1'b0; out_ready = 1'b0;
    op_code8 = '0; alu_result8 = '0; frame_start8 = 1'b0; out_ready8 = 1'b0;
    stall_seen = 1'b0; stall8_seen = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_out_we",     32'(out_we),     32'd0);
    check("rst_out_addr",   32'(out_addr),   32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_pix_count",  32'(pix_count),  32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // GP pixel in IDLE is dropped silently
    out_ready = 1'b1;
    push(8'hEE);
    tick(2);
    check("idle_no_write", 32'(log_q.size()), 32'd0);
    check("idle_no_ovf",   32'(overflow),     32'd0);

    // Test 1: four pixels with the memory always ready
    pulse_fs();
    stall_seen = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(4);
    check("t1_nwrites", 32'(log_q.size()), 32'd4);
    check("t1_w0", log_at(0), entry(0, 8'h11));
    check("t1_w1", log_at(1), entry(1, 8'h22));
    check("t1_w2", log_at(2), entry(2, 8'h33));
    check("t1_w3", log_at(3), entry(3, 8'h44));
    check("t1_pix_count", 32'(pix_count), 32'd4);
    check("t1_no_stall",  32'(stall_seen), 32'd0);

    // Test 2/4: fill the FIFO with the memory blocked, then drain
    pulse_fs();
    log_q.delete();
    out_ready = 1'b0;
    stall_seen = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    check("t2_no_stall_16", 32'(stall_seen), 32'd0);
    op_code = 5'd10;
    alu_result = 32'h90;
    @(negedge clk);
    check("t2_stall_17th", 32'(stall),    32'd1);
    check("t2_hold_we",    32'(out_we),   32'd1);
    check("t2_hold_addr",  32'(out_addr), 32'd0);
    check("t2_hold_data",  32'(out_data), 32'h80);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_stall_full_pop", 32'(stall), 32'd1);
    tick();
    idx = 16;
    cyc = 0;
    while (idx < 20 && cyc < 100) begin
      op_code = 5'd10;
      alu_result = 32'h80 + 32'(idx);
      @(negedge clk);
      s = stall;
      tick();
      if (!s) idx++;
      cyc++;
    end
    op_code = 5'd0;
    check("t2_all_pushed", 32'(idx), 32'd20);
    cyc = 0;
    while (log_q.size() < 20 && cyc < 100) begin
      tick();
      cyc++;
    end
    tick(2);
    check("t2_nwrites", 32'(log_q.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      check($sformatf("t2_w%0d", i), log_at(i), entry(i, 8'h80 + i));

    // Test 3: 8-pixel frame completes, then a late pixel overflows
    pulse_fs8();
    out_ready8 = 1'b1;
    stall8_seen = 1'b0;
    for (int i = 1; i <= 8; i++) push8(8'(i));
    tick(4);
    check("t3_nwrites",   32'(log8_q.size()), 32'd8);
    check("t3_w7",        log8_at(7), entry(7, 8'h08));
    check("t3_fd_once",   32'(fd8_cnt), 32'd1);
    check("t3_fd_align",  32'(fd8_cyc), 32'(hs7_cyc + 1));
    check("t3_pix_count", 32'(pix_count8), 32'd8);
    check("t3_ovf_pre",   32'(overflow8), 32'd0);
    push8(8'h09);
    tick(3);
    check("t3_overflow",  32'(overflow8), 32'd1);
    check("t3_no_9th",    32'(log8_q.size()), 32'd8);
    check("t3_we_done",   32'(out_we8), 32'd0);
    check("t3_no_stall",  32'(stall8_seen), 32'd0);

    // Test 5: reset with five pixels buffered
    pulse_fs();
    log_q.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'h50 + 8'(i));
    check("t5_we_before", 32'(out_we), 32'd1);
    op_code = 5'd10;
    alu_result = 32'h56;
    #2;
    rst = 1'b0;
    #1;
    check("t5_we",       32'(out_we),    32'd0);
    check("t5_addr",     32'(out_addr),  32'd0);
    check("t5_data",     32'(out_data),  32'd0);
    check("t5_pix",      32'(pix_count), 32'd0);
    check("t5_stall",    32'(stall),     32'd0);
    check("t5_ovf",      32'(overflow),  32'd0);
    check("t5_fd",       32'(frame_done), 32'd0);
    op_code = 5'd0;
    tick(2);
    rst = 1'b1;
    tick();
    check("t5_no_write", 32'(log_q.size()), 32'd0);
    out_ready = 1'b1;
    pulse_fs();
    push(8'hA5);
    tick(3);
    check("t5_nwrites", 32'(log_q.size()), 32'd1);
    check("t5_w0",      log_at(0), entry(0, 8'hA5));

    // Test 6: excess pixels overflow in ACTIVE, then abort mid-frame
    pulse_fs8();
    log8_q.delete();
    out_ready8 = 1'b1;
    push8(8'h31); push8(8'h32); push8(8'h33);
    tick(3);
    check("t6_pix3", 32'(pix_count8), 32'd3);
    out_ready8 = 1'b0;
    for (int i = 1; i <= 5; i++) push8(8'h40 + 8'(i));
    check("t6_ovf_pre", 32'(overflow8), 32'd0);
    op_code8 = 5'd10;
    alu_result8 = 32'h46;
    @(negedge clk);
    check("t6_excess_no_stall", 32'(stall8), 32'd0);
    tick();
    op_code8 = 5'd0;
    check("t6_excess_ovf", 32'(overflow8), 32'd1);
    pulse_fs8();
    check("t6_abort_pix", 32'(pix_count8), 32'd0);
    check("t6_abort_ovf", 32'(overflow8),  32'd0);
    check("t6_abort_we",  32'(out_we8),    32'd0);
    log8_q.delete();
    out_ready8 = 1'b1;
    push8(8'hEE);
    tick(3);
    check("t6_nwrites", 32'(log8_q.size()), 32'd1);
    check("t6_w0",      log8_at(0), entry(0, 8'hEE));
    check("t6_no_fd",   32'(fd8_cnt), 32'd1);
    check("default_no_fd", 32'(fd_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
